// File: rtl/pipe_rca_pkg.sv
// pipe_rca_pkg: shared stage control type and chunk sizing for the pipelined ripple-carry adder
package pipe_rca_pkg;
  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
  } stage_ctl_t;
  function automatic int chunk_w(input int w, input int stages);
    return w / stages;
  endfunction
endpackage

// File: rtl/pipe_rca_adder_if.sv
// pipe_rca_adder_if: operand/result stream bundle; the sub signal exists only with PIPE_RCA_SUB_EN
interface pipe_rca_adder_if
  import pipe_rca_pkg::*;
#(
  parameter int W = 8
);
  logic in_valid, in_ready, cin, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [W:0] sum;
`ifdef PIPE_RCA_SUB_EN
  logic sub;
  modport master (output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum);
  modport slave (input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum);
`else
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum);
`endif
endinterface

// File: rtl/pipe_rca_stage.sv
// pipe_rca_stage: one C-bit ripple slice with its result/control registers and advance logic
module pipe_rca_stage
  import pipe_rca_pkg::*;
#(
  parameter int C = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  stage_ctl_t ci,
  input  logic [C-1:0] a_c,
  input  logic [C-1:0] b_c,
  input  logic       nxt,
  output logic       rdy,
  output stage_ctl_t cq,
  output logic [C-1:0] s_q
);
  logic [C:0] add;
  assign rdy = ~cq.valid | nxt;
  assign add = {1'b0, a_c} + {1'b0, ci.sub ? ~b_c : b_c} + {{C{1'b0}}, ci.carry};
  // Data only moves with a real beat, so the last result stays visible after out_valid drops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cq <= '0;
      s_q <= '0;
    end else if (rdy) begin
      cq.valid <= ci.valid;
      if (ci.valid) begin
        cq.carry <= add[C];
        cq.sub <= ci.sub;
        s_q <= add[C-1:0];
      end
    end
endmodule

// File: rtl/pipe_rca_adder.sv
// pipe_rca_adder: W-bit ripple-carry add pipelined over STAGES chunk slices with valid/ready flow control
// PIPE_RCA_SUB_EN adds a sub input that turns the operation into a - b (sum[W]=1 means no borrow)
module pipe_rca_adder
  import pipe_rca_pkg::*;
#(
  parameter int W = 8,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  pipe_rca_adder_if.slave io
);
  localparam int C = chunk_w(W, STAGES);
  logic sub0;
  if (STAGES < 1 || STAGES > W || W % STAGES != 0) begin : g_bad
    $error("pipe_rca_adder: W must be a multiple of STAGES with 1 <= STAGES <= W");
  end
`ifdef PIPE_RCA_SUB_EN
  assign sub0 = io.sub;
`else
  assign sub0 = 1'b0;
`endif
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [W-k*C-1:0] a_in, b_in;
    logic [(k+1)*C-1:0] sw;
    logic [C-1:0] s_c;
    stage_ctl_t ci, cq;
    logic rdy, nxt;
    if (k == 0) begin : g_src
      assign a_in = io.a;
      assign b_in = io.b;
      assign ci = '{valid: io.in_valid, carry: sub0 | io.cin, sub: sub0};
      assign sw = s_c;
    end else begin : g_src
      logic [k*C-1:0] lo_q;
      assign a_in = g_st[k-1].g_up.a_q;
      assign b_in = g_st[k-1].g_up.b_q;
      assign ci = g_st[k-1].cq;
      assign sw = {s_c, lo_q};
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lo_q <= '0;
        else if (rdy && ci.valid) lo_q <= g_st[k-1].sw;
    end
    // Operand bits not yet consumed ride along with the beat to later slices
    if (k < STAGES - 1) begin : g_up
      logic [W-(k+1)*C-1:0] a_q, b_q;
      assign nxt = g_st[k+1].rdy;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy && ci.valid) begin
          a_q <= a_in[W-k*C-1:C];
          b_q <= b_in[W-k*C-1:C];
        end
    end else begin : g_last
      assign nxt = io.out_ready;
    end
    pipe_rca_stage #(.C(C)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .ci(ci),
      .a_c(a_in[C-1:0]),
      .b_c(b_in[C-1:0]),
      .nxt(nxt),
      .rdy(rdy),
      .cq(cq),
      .s_q(s_c)
    );
  end
  // in_ready ripples combinationally back from out_ready through the stage ready chain
  assign io.in_ready = g_st[0].rdy;
  assign io.out_valid = g_st[STAGES-1].cq.valid;
  assign io.sum = {g_st[STAGES-1].cq.carry, g_st[STAGES-1].sw};
endmodule

// File: tb/tb_pipe_rca_adder.sv
// tb_pipe_rca_adder: directed 8-bit/2-stage vectors plus a random 16-bit/4-stage scoreboard run
module tb_pipe_rca_adder;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic cin;
    logic [8:0] exp;
  } vec_t;
  logic clk = 0, rst_n = 1;
  int errors = 0, checks = 0, cyc = 0, n16 = 0;
  logic [8:0] q8[$];
  logic [16:0] q16[$];
  int ic8[$], oc8[$];
  vec_t tbl[8];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pipe_rca_adder_if #(.W(8)) i8 ();
  pipe_rca_adder_if #(.W(16)) i16 ();
  pipe_rca_adder #(.W(8), .STAGES(2)) d8 (.clk(clk), .rst_n(rst_n), .io(i8.slave));
  pipe_rca_adder #(.W(16), .STAGES(4)) d16 (.clk(clk), .rst_n(rst_n), .io(i16.slave));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [16:0] model16(input logic [15:0] a, b, input logic c, s);
    return s ? {1'b0, a} + {1'b0, ~b} + 17'd1 : {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  function automatic logic sub16();
`ifdef PIPE_RCA_SUB_EN
    return i16.sub;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk)
    if (!rst_n) q8.delete();
    else if (i8.out_valid && i8.out_ready) begin
      oc8.push_back(cyc);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d8_unexpected: got beat %0h, expected none", i8.sum);
      end else chk("d8_sum", i8.sum, q8.pop_front());
    end

  always @(negedge clk)
    if (!rst_n) q16.delete();
    else begin
      if (i16.out_valid && i16.out_ready) begin
        n16++;
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d16_unexpected: got beat %0h, expected none", i16.sum);
        end else chk("d16_sum", i16.sum, q16.pop_front());
      end
      if (i16.in_valid && i16.in_ready) q16.push_back(model16(i16.a, i16.b, i16.cin, sub16()));
    end

  task automatic send8(input vec_t v, input logic s);
    bit ok = 0;
    i8.in_valid = 1;
    i8.a = v.a;
    i8.b = v.b;
    i8.cin = v.cin;
`ifdef PIPE_RCA_SUB_EN
    i8.sub = s;
`endif
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (i8.in_ready) begin
        ok = 1;
        q8.push_back(v.exp);
        ic8.push_back(cyc);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL d8_accept: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("d8_drain", q8.size(), 0);
  endtask

  initial begin
    logic [8:0] held;
    int n, sent;
    bit acc;
    i8.in_valid = 0; i8.a = 0; i8.b = 0; i8.cin = 0; i8.out_ready = 1;
    i16.in_valid = 0; i16.a = 0; i16.b = 0; i16.cin = 0; i16.out_ready = 1;
`ifdef PIPE_RCA_SUB_EN
    i8.sub = 0;
    i16.sub = 0;
`endif
    tbl[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    tbl[1] = '{8'h10, 8'h20, 1'b0, 9'h030};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 9'h080};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 9'h100};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 9'h000};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 9'h100};
    tbl[7] = '{8'hC3, 8'h3C, 1'b0, 9'h0FF};
    #1 rst_n = 0;
    #1;
    chk("rst_out_valid", i8.out_valid, 0);
    chk("rst_sum", i8.sum, 0);
    chk("rst_out_valid16", i16.out_valid, 0);
    #10 rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", i8.in_ready, 1);
    // single beat latency
    ic8.delete(); oc8.delete();
    send8(tbl[0], 0);
    i8.in_valid = 0;
    drain8();
    chk("lat_beats", oc8.size(), 1);
    if (oc8.size() == 1 && ic8.size() == 1) chk("latency", oc8[0] - ic8[0], 2);
    // back-to-back stream from the table
    oc8.delete();
    for (int i = 1; i < 8; i++) send8(tbl[i], 0);
    i8.in_valid = 0;
    drain8();
    chk("stream_beats", oc8.size(), 7);
    if (oc8.size() == 7) chk("stream_consecutive", oc8[6] - oc8[0], 6);
    // back-pressure: consumer stalls while the producer keeps offering beats
    oc8.delete();
    i8.out_ready = 0;
    n = 0;
    held = 0;
    for (int c = 0; c < 5; c++) begin
      i8.in_valid = 1;
      i8.a = 8'h40 + 8'(n);
      i8.b = 8'(n);
      i8.cin = 0;
      @(negedge clk);
      if (c == 2) held = i8.sum;
      if (c > 2) chk("stall_sum_hold", i8.sum, held);
      if (i8.in_ready) begin
        q8.push_back({1'b0, i8.a} + {1'b0, i8.b});
        n++;
      end
      @(posedge clk);
      #1;
    end
    chk("stall_in_ready", i8.in_ready, 0);
    chk("stall_out_valid", i8.out_valid, 1);
    chk("stall_accepted", n, 2);
    i8.in_valid = 0;
    i8.out_ready = 1;
    drain8();
    chk("stall_released", oc8.size(), 2);
    // reset with two beats in flight
    oc8.delete();
    send8(tbl[1], 0);
    send8(tbl[2], 0);
    i8.in_valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", i8.out_valid, 0);
    chk("midrst_sum", i8.sum, 0);
    chk("midrst_in_ready", i8.in_ready, 1);
    @(negedge clk);
    #2 rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", oc8.size(), 0);
    chk("midrst_queue", q8.size(), 0);
`ifdef PIPE_RCA_SUB_EN
    send8('{8'h05, 8'h07, 1'b0, 9'h0FE}, 1);
    send8('{8'h07, 8'h05, 1'b1, 9'h102}, 1);
    i8.in_valid = 0;
    drain8();
`endif
    // random 16-bit stream with random back-pressure
    sent = 0;
    acc = 1;
    for (int c = 0; c < 40000 && sent < 10000; c++) begin
      if (!i16.in_valid || acc) begin
        i16.in_valid = $urandom_range(0, 3) != 0;
        i16.a = 16'($urandom);
        i16.b = 16'($urandom);
        i16.cin = 1'($urandom);
`ifdef PIPE_RCA_SUB_EN
        i16.sub = 1'($urandom);
`endif
      end
      i16.out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      acc = i16.in_valid && i16.in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
    end
    i16.in_valid = 0;
    i16.out_ready = 1;
    chk("d16_sent", sent, 10000);
    for (int i = 0; i < 60 && q16.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("d16_drain", q16.size(), 0);
    chk("d16_count", n16, sent);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
